nolan_led_pwm_lab3: RTL and testbench

Downstream brightness stage for the LED blink slot core: consumes its `led_out` vector on `led_in` and drives the physical LED pins with a per-LED PWM-dimmed (optionally inverted) version of each blink waveform. Sits on its own MMIO slot (same `cs/read/write/addr/wr_data/rd_data` slot interface) so software can set per-LED duty, PWM rate and a bypass. Out of reset the block is in bypass, so the blink core drives the pins unchanged.

---
 rtl/nolan_led_pwm_lab3.sv | 218 +++++++++++++++++++++
 tb/tb_nolan_led_pwm_lab3.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nolan_led_pwm_lab3.sv
// -----------------------------------------------------------------------------
// nolan_led_pwm_lab3
//
// Brightness stage that sits after the LED blink core. Each blink waveform bit
// arriving on led_in is registered, optionally PWM-dimmed with a per-channel
// duty value, optionally inverted, and registered again onto led_pwm. Out of
// reset the block is in bypass (en = 0), so the pins follow led_in two cycles
// later.
//
// Optional feature macro: LED_PWM_FADE_EN
//   defined     : the effective duty ramps one step per PWM period toward its
//                 target (linear fade in/out following blink edges).
//   not defined : the effective duty jumps to its target at each period start.
//
// Ports
//   clk      : system clock, all logic on the rising edge
//   reset    : asynchronous active-low reset (0 = in reset)
//   cs       : slot select
//   read     : slot read strobe (not needed; reads are combinational)
//   write    : slot write strobe, register written when cs & write
//   addr     : register index
//                0..N_LED-1 duty[i]   8 presc   9 ctrl {inv,en}
//                10 status {pwm_cnt at [PWM_BITS+15:16], led_q at [N_LED-1:0]}
//   wr_data  : write data
//   rd_data  : read data, combinational on addr, zero for unlisted addresses
//   led_in   : blink waveform from the blink core
//   led_pwm  : registered pin drive
// -----------------------------------------------------------------------------
module nolan_led_pwm_lab3 #(
   parameter int N_LED    = 4,
   parameter int PWM_BITS = 8,
   parameter int PRESC_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cs,
   input  logic               read,
   input  logic               write,
   input  logic [4:0]         addr,
   input  logic [31:0]        wr_data,
   output logic [31:0]        rd_data,
   input  logic [N_LED-1:0]   led_in,
   output logic [N_LED-1:0]   led_pwm
);

   localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
   localparam logic [PWM_BITS-1:0] CNT_ONE = 1;
   localparam logic [PRESC_W-1:0]  PC_ONE  = 1;

   // Register file
   logic [N_LED-1:0][PWM_BITS-1:0] duty_q, duty_d;
   logic [PRESC_W-1:0]             presc_q, presc_d;
   logic                           en_q, en_d;
   logic                           inv_q, inv_d;

   // Datapath state
   logic [N_LED-1:0]               led_q, led_d;
   logic [PRESC_W-1:0]             pc_q, pc_d;
   logic [PWM_BITS-1:0]            pwm_cnt_q, pwm_cnt_d;
   logic [N_LED-1:0][PWM_BITS-1:0] eff_q, eff_d;
   logic [N_LED-1:0]               led_pwm_q, led_pwm_d;

   // Combinational helpers
   logic                           wr_en;
   logic                           tick;
   logic                           pstart;
   logic [N_LED-1:0][PWM_BITS-1:0] tgt;
   logic [N_LED-1:0]               raw;
   logic [31:0]                    rd_data_c;

   // The read strobe and the unused upper write-data bits are deliberately
   // ignored; folding them here keeps that decision explicit.
   logic unused_sig;
   assign unused_sig = ^{read, wr_data};

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_en     = cs & write;
      duty_d    = duty_q;
      presc_d   = presc_q;
      en_d      = en_q;
      inv_d     = inv_q;
      led_d     = led_in;
      pc_d      = pc_q;
      pwm_cnt_d = pwm_cnt_q;
      eff_d     = eff_q;

      // Register writes
      for (int i = 0; i < N_LED; i++) begin
         if (wr_en && (addr == 5'(i))) begin
            duty_d[i] = wr_data[PWM_BITS-1:0];
         end
      end
      if (wr_en && (addr == 5'd8)) begin
         presc_d = wr_data[PRESC_W-1:0];
      end
      if (wr_en && (addr == 5'd9)) begin
         en_d  = wr_data[0];
         inv_d = wr_data[1];
      end

      // Target duty follows the registered blink level; uses the duty value
      // already in the register, so a write landing on a period start is only
      // seen at the following period start.
      for (int i = 0; i < N_LED; i++) begin
         tgt[i] = led_q[i] ? duty_q[i] : '0;
      end

      tick   = (pc_q == presc_q);
      pstart = en_q & tick & (pwm_cnt_q == CNT_MAX);

      if (!en_d) begin
         // Disabled (or being disabled): counters and effective duty parked.
         pc_d      = '0;
         pwm_cnt_d = '0;
         eff_d     = '0;
      end else if (!en_q) begin
         // Enable edge: start a fresh period right away instead of waiting for
         // a period boundary.
         pc_d      = '0;
         pwm_cnt_d = '0;
`ifdef LED_PWM_FADE_EN
         eff_d     = '0;
`else
         eff_d     = tgt;
`endif
      end else begin
         pc_d = tick ? '0 : (pc_q + PC_ONE);
         // A new reload value restarts the prescaler so pc never sits above it.
         if (wr_en && (addr == 5'd8)) begin
            pc_d = '0;
         end
         if (tick) begin
            pwm_cnt_d = pwm_cnt_q + CNT_ONE;
         end
         if (pstart) begin
            for (int i = 0; i < N_LED; i++) begin
`ifdef LED_PWM_FADE_EN
               if (eff_q[i] < tgt[i]) begin
                  eff_d[i] = eff_q[i] + CNT_ONE;
               end else if (eff_q[i] > tgt[i]) begin
                  eff_d[i] = eff_q[i] - CNT_ONE;
               end
`else
               eff_d[i] = tgt[i];
`endif
            end
         end
      end

      // PWM compare; full-scale duty is forced high so it never drops out for
      // the one count where pwm_cnt == max.
      for (int i = 0; i < N_LED; i++) begin
         if (!en_q) begin
            raw[i] = led_q[i];
         end else if (eff_q[i] == CNT_MAX) begin
            raw[i] = 1'b1;
         end else begin
            raw[i] = (pwm_cnt_q < eff_q[i]);
         end
      end
      led_pwm_d = raw ^ {N_LED{inv_q}};
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         duty_q    <= '0;
         presc_q   <= '0;
         en_q      <= 1'b0;
         inv_q     <= 1'b0;
         led_q     <= '0;
         pc_q      <= '0;
         pwm_cnt_q <= '0;
         eff_q     <= '0;
         led_pwm_q <= '0;
      end else begin
         duty_q    <= duty_d;
         presc_q   <= presc_d;
         en_q      <= en_d;
         inv_q     <= inv_d;
         led_q     <= led_d;
         pc_q      <= pc_d;
         pwm_cnt_q <= pwm_cnt_d;
         eff_q     <= eff_d;
         led_pwm_q <= led_pwm_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Read mux (independent of cs/read)
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_data_c = '0;
      for (int i = 0; i < N_LED; i++) begin
         if (addr == 5'(i)) begin
            rd_data_c[PWM_BITS-1:0] = duty_q[i];
         end
      end
      case (addr)
         5'd8: rd_data_c[PRESC_W-1:0] = presc_q;
         5'd9: rd_data_c[1:0] = {inv_q, en_q};
         5'd10: begin
            rd_data_c[N_LED-1:0]        = led_q;
            rd_data_c[PWM_BITS+15:16]   = pwm_cnt_q;
         end
         default: ;
      endcase
   end

   assign rd_data = rd_data_c;
   assign led_pwm = led_pwm_q;

endmodule

// File: tb/tb_nolan_led_pwm_lab3.sv
// -----------------------------------------------------------------------------
// tb_nolan_led_pwm_lab3
//
// Directed bench for nolan_led_pwm_lab3 in its default build (N_LED=4,
// PWM_BITS=8, PRESC_W=16, fade disabled). Inputs change on the falling edge,
// outputs are sampled on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_nolan_led_pwm_lab3;

   logic        clk;
   logic        reset;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [3:0]  led_in;
   logic [3:0]  led_pwm;

   int          n_checks;
   int          n_fail;
   logic [3:0]  exp_q[$];

   nolan_led_pwm_lab3 #(
      .N_LED   (4),
      .PWM_BITS(8),
      .PRESC_W (16)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .cs     (cs),
      .read   (read),
      .write  (write),
      .addr   (addr),
      .wr_data(wr_data),
      .rd_data(rd_data),
      .led_in (led_in),
      .led_pwm(led_pwm)
   );

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Checker
   // ---------------------------------------------------------------------------
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   // Returns on the falling edge right after the capturing rising edge.
   task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      cs      = 1'b1;
      write   = 1'b1;
      addr    = a;
      wr_data = d;
      @(negedge clk);
      cs      = 1'b0;
      write   = 1'b0;
   endtask

   task automatic rd_reg(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a;
      #1;
      d = rd_data;
   endtask

   task automatic count_high(input int idx, input int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         c += int'(led_pwm[idx]);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   logic [3:0] byp_vec [8];
   initial begin
      byp_vec[0] = 4'h5; byp_vec[1] = 4'hA; byp_vec[2] = 4'h3; byp_vec[3] = 4'hC;
      byp_vec[4] = 4'h0; byp_vec[5] = 4'h9; byp_vec[6] = 4'h6; byp_vec[7] = 4'hF;
   end

   initial begin : main
      logic [31:0] rd;
      int          c;
      int          c1;
      int          c2;

      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      cs       = 1'b0;
      read     = 1'b0;
      write    = 1'b0;
      addr     = '0;
      wr_data  = '0;
      led_in   = 4'hF;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check_val("reset_led_pwm", {28'd0, led_pwm}, 32'h0);
      rd_reg(5'd0, rd);
      check_val("reset_rd_addr0", rd, 32'h0);
      rd_reg(5'd9, rd);
      check_val("reset_rd_ctrl", rd, 32'h0);
      reset = 1'b1;

      // ---- bypass ----
      repeat (3) @(negedge clk);
      check_val("bypass_static", {28'd0, led_pwm}, 32'hF);
      exp_q.push_back(4'hF);
      exp_q.push_back(4'hF);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_val("bypass_latency", {28'd0, led_pwm}, {28'd0, exp_q.pop_front()});
         if (i < 8) begin
            led_in = byp_vec[i];
            exp_q.push_back(byp_vec[i]);
         end
      end

      // ---- PWM presc=0, duty[0]=64 ----
      wr_reg(5'd0, 32'd64);
      wr_reg(5'd9, 32'd1);
      addr = 5'd10;
      #1;
      check_val("status_cnt_start", rd_data, 32'h0000_000F);
      @(negedge clk);
      #1;
      check_val("status_cnt_step", rd_data, 32'h0001_000F);
      repeat (10) @(negedge clk);
      count_high(0, 256, c);
      check_val("duty64_high", c, 64);
      count_high(1, 256, c);
      check_val("duty0_ch1_low", c, 0);
      wr_reg(5'd0, 32'd255);
      repeat (300) @(negedge clk);
      count_high(0, 256, c);
      check_val("duty255_high", c, 256);
      wr_reg(5'd0, 32'd0);
      repeat (300) @(negedge clk);
      count_high(0, 256, c);
      check_val("duty0_low", c, 0);

      // ---- presc=3, duty[1]=128, mid-period change to 32 ----
      wr_reg(5'd9, 32'd0);
      wr_reg(5'd1, 32'd128);
      wr_reg(5'd8, 32'd3);
      wr_reg(5'd9, 32'd1);
      c1 = 0;
      c2 = 0;
      for (int k = 1; k <= 2048; k++) begin
         @(negedge clk);
         if (k <= 1024) c1 += int'(led_pwm[1]);
         else           c2 += int'(led_pwm[1]);
         if (k == 200) begin
            cs = 1'b1; write = 1'b1; addr = 5'd1; wr_data = 32'd32;
         end
         if (k == 201) begin
            cs = 1'b0; write = 1'b0;
         end
      end
      check_val("presc3_old_duty", c1, 512);
      check_val("presc3_new_duty", c2, 128);

      // ---- inversion ----
      wr_reg(5'd9, 32'd0);
      wr_reg(5'd8, 32'd0);
      wr_reg(5'd2, 32'd64);
      wr_reg(5'd9, 32'd3);
      repeat (10) @(negedge clk);
      count_high(2, 256, c);
      check_val("inv_duty64_low", 256 - c, 64);
      count_high(0, 256, c);
      check_val("inv_duty0_high", c, 256);
      led_in = 4'hB;
      repeat (300) @(negedge clk);
      count_high(2, 256, c);
      check_val("inv_ledoff_high", c, 256);

      // ---- readback ----
      wr_reg(5'd0, 32'd10);
      wr_reg(5'd1, 32'd20);
      wr_reg(5'd2, 32'd30);
      wr_reg(5'd3, 32'd40);
      wr_reg(5'd8, 32'd7);
      wr_reg(5'd9, 32'd3);
      wr_reg(5'd5, 32'h55);
      rd_reg(5'd0, rd);  check_val("rd_duty0", rd, 32'd10);
      rd_reg(5'd1, rd);  check_val("rd_duty1", rd, 32'd20);
      rd_reg(5'd2, rd);  check_val("rd_duty2", rd, 32'd30);
      rd_reg(5'd3, rd);  check_val("rd_duty3", rd, 32'd40);
      rd_reg(5'd8, rd);  check_val("rd_presc", rd, 32'd7);
      rd_reg(5'd9, rd);  check_val("rd_ctrl", rd, 32'd3);
      rd_reg(5'd5, rd);  check_val("rd_addr5", rd, 32'd0);
      rd_reg(5'd4, rd);  check_val("rd_addr4", rd, 32'd0);
      rd_reg(5'd10, rd); check_val("rd_status_led", rd & 32'hFF, 32'hB);

      // ---- disable: counters cleared, bypass ----
      wr_reg(5'd9, 32'd0);
      addr = 5'd10;
      #1;
      check_val("disable_status", rd_data, 32'h0000_000B);
      repeat (2) @(negedge clk);
      check_val("disable_bypass", {28'd0, led_pwm}, 32'hB);

      // ---- asynchronous reset mid-period ----
      wr_reg(5'd9, 32'd1);
      repeat (37) @(negedge clk);
      #3;
      reset = 1'b0;
      #1;
      check_val("async_reset_pins", {28'd0, led_pwm}, 32'h0);
      rd_reg(5'd3, rd);
      check_val("async_reset_duty", rd, 32'h0);
      rd_reg(5'd9, rd);
      check_val("async_reset_ctrl", rd, 32'h0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_val("post_reset_bypass", {28'd0, led_pwm}, 32'hB);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
